// File: rtl/cub_sqrt_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cub_sqrt_sched_pkg
// Description : Shared types and defaults for the cub_sqrt round-robin
//               scheduler. Holds the FSM state encoding and the default
//               operand width / watchdog depth used by cub_sqrt_sched.
// Revision    : 1.0 - initial release
// ============================================================================
package cub_sqrt_sched_pkg;

  // Scheduler FSM states; explicit 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // Defaults matching the cub_sqrt unit this scheduler fronts.
  localparam int DEF_NREQ    = 4;
  localparam int DEF_XW      = 8;
  localparam int DEF_TIMEOUT = 64;

  // Watchdog counter width: enough to hold TIMEOUT-1 with one bit of margin.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage : cub_sqrt_sched_pkg
`default_nettype wire

// File: rtl/cub_sqrt_sched_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority picker. Searches the
//               request vector upward, circularly, starting one position
//               above the pointer, and returns the first set bit.
// Ports       : req_i  - request vector (NREQ)
//               ptr_i  - last-granted index (IDW)
//               gnt_o  - one-hot grant (NREQ)
//               id_o   - encoded grant index (IDW)
//               any_o  - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  id_o,
  output logic            any_o
);

  // One extra bit so ptr+k never wraps before the explicit modulo-NREQ step;
  // ptr < NREQ and k <= NREQ keep the sum below 2*NREQ.
  logic [IDW:0]   sum_w;
  logic [IDW-1:0] idx_w;

  always_comb begin
    id_o  = '0;
    any_o = 1'b0;
    sum_w = '0;
    idx_w = '0;
    // k = NREQ wraps back to the pointer itself, so the last holder is
    // served again only when nobody else is asking.
    for (int k = 1; k <= NREQ; k++) begin
      sum_w = {1'b0, ptr_i} + (IDW+1)'(k);
      if (sum_w >= (IDW+1)'(NREQ)) begin
        sum_w = sum_w - (IDW+1)'(NREQ);
      end
      idx_w = sum_w[IDW-1:0];
      if (!any_o && req_i[idx_w]) begin
        any_o = 1'b1;
        id_o  = idx_w;
      end
    end
  end

  assign gnt_o = any_o ? (NREQ'(1) << id_o) : '0;

endmodule : rr_pick
`default_nettype wire

// File: rtl/cub_sqrt_sched.sv
`default_nettype none
// ============================================================================
// Module      : cub_sqrt_sched
// Description : Round-robin scheduler sharing one cub_sqrt unit between NREQ
//               requesters. Grants one request at a time, latches its
//               operand, pulses the unit's start, follows its busy, and
//               returns the result tagged with the requester id. A watchdog
//               aborts an operation the unit never completes.
// Ports       : clk_i      - clock, all state on the rising edge
//               rst_i      - asynchronous active-low reset
//               req_bi     - per-requester request levels
//               x_bi       - flattened operands, requester k at [k*XW +: XW]
//               ack_bo     - one-hot accept pulse (ISSUE cycle)
//               busy_o     - scheduler not idle
//               done_o     - result-valid pulse
//               err_o      - with done_o: the operation timed out
//               id_bo      - requester id of the current / last result
//               y_bo       - result
//               cs_start_o - start pulse to the unit
//               cs_x_bo    - operand to the unit
//               cs_busy_i  - unit busy
//               cs_y_bi    - unit result
// Revision    : 1.0 - initial release
// ============================================================================
module cub_sqrt_sched
  import cub_sqrt_sched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int XW      = DEF_XW,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NREQ-1:0]  req_bi,
  input  logic [NREQ*XW-1:0] x_bi,
  output logic [NREQ-1:0]  ack_bo,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [IDW-1:0]   id_bo,
  output logic [XW-1:0]    y_bo,
  output logic             cs_start_o,
  output logic [XW-1:0]    cs_x_bo,
  input  logic             cs_busy_i,
  input  logic [XW-1:0]    cs_y_bi
);

  localparam int             CNTW     = cnt_width(TIMEOUT);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [IDW-1:0]  PTR_RST  = IDW'(NREQ - 1);

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q,   ptr_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;
  logic [NREQ-1:0] ack_q,   ack_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;
  logic            err_q,   err_d;
  logic            start_q, start_d;
  logic [IDW-1:0]  id_q,    id_d;
  logic [XW-1:0]   y_q,     y_d;
  logic [XW-1:0]   x_q,     x_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [NREQ-1:0] gnt_w;
  logic [IDW-1:0]  gid_w;
  logic            any_w;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req_i (req_bi),
    .ptr_i (ptr_q),
    .gnt_o (gnt_w),
    .id_o  (gid_w),
    .any_o (any_w)
  );

  // Unpack the flattened operand bus so the winner can be selected by id.
  logic [XW-1:0] x_vec_w [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_opnd
    assign x_vec_w[k] = x_bi[k*XW +: XW];
  end

  logic [XW-1:0] x_sel_w;
  assign x_sel_w = x_vec_w[gid_w];

  // Watchdog fires on the last permitted cycle of WAIT_BUSY/RUN and wins
  // over any busy transition seen in the same cycle.
  logic in_wait_w;
  logic timeout_w;
  assign in_wait_w = (state_q == ST_WAIT_BUSY) || (state_q == ST_RUN);
  assign timeout_w = in_wait_w && (cnt_q == CNT_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      id_q    <= '0;
      y_q     <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      id_q    <= id_d;
      y_q     <= y_d;
      x_q     <= x_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_w) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (timeout_w)      state_d = ST_DONE;
        else if (cs_busy_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (timeout_w || !cs_busy_i) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath logic
  // --------------------------------------------------------------------------
  // Every visible output is computed from the state being entered, so the
  // registered copy lines up with that state's cycle.
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    y_d     = y_q;
    x_d     = x_q;
    ack_d   = '0;
    start_d = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_DONE) && timeout_w;

    unique case (state_q)
      ST_IDLE: begin
        if (any_w) begin
          x_d     = x_sel_w;
          id_d    = gid_w;
          ptr_d   = gid_w;
          ack_d   = gnt_w;
          start_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
      end
      ST_WAIT_BUSY, ST_RUN: begin
        if (timeout_w) begin
          y_d = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
          if (state_q == ST_RUN && !cs_busy_i) begin
            y_d = cs_y_bi;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output assignments
  // --------------------------------------------------------------------------
  assign ack_bo     = ack_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign id_bo      = id_q;
  assign y_bo       = y_q;
  assign cs_start_o = start_q;
  assign cs_x_bo    = x_q;

endmodule : cub_sqrt_sched
`default_nettype wire

// File: tb/tb_cub_sqrt_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cub_sqrt_sched
// Description : Self-checking bench for cub_sqrt_sched. A behavioural
//               cub_sqrt stand-in (variable latency, optional stuck-busy
//               mode) sits on the unit side; expected grants and results
//               come from a round-robin rule and an integer cube root.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cub_sqrt_sched;

  localparam int NREQ    = 4;
  localparam int XW      = 8;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_bi;
  logic [NREQ*XW-1:0] x_bi;
  logic [NREQ-1:0]    ack_bo;
  logic               busy_o, done_o, err_o;
  logic [IDW-1:0]     id_bo;
  logic [XW-1:0]      y_bo;
  logic               cs_start_o;
  logic [XW-1:0]      cs_x_bo;
  logic               cs_busy_i;
  logic [XW-1:0]      cs_y_bi;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_ptr;

  always #5 clk = ~clk;

  cub_sqrt_sched #(
    .NREQ(NREQ), .XW(XW), .IDW(IDW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .req_bi(req_bi), .x_bi(x_bi),
    .ack_bo(ack_bo), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .id_bo(id_bo), .y_bo(y_bo), .cs_start_o(cs_start_o), .cs_x_bo(cs_x_bo),
    .cs_busy_i(cs_busy_i), .cs_y_bi(cs_y_bi)
  );

  // ---------------- reference rules ----------------
  function automatic logic [XW-1:0] icbrt(input logic [XW-1:0] x);
    int r = 0;
    while ((r+1)*(r+1)*(r+1) <= int'(x)) r++;
    return XW'(r);
  endfunction

  function automatic int model_pick(input logic [NREQ-1:0] req, input int ptr);
    for (int k = 1; k <= NREQ; k++) begin
      int c = (ptr + k) % NREQ;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // ---------------- cub_sqrt stand-in ----------------
  logic          unit_rst_n;
  logic          u_arst_n;
  bit            stub;
  int            unit_b;
  int            u_cnt;
  logic [XW-1:0] u_x;
  assign u_arst_n = rst_n & unit_rst_n;

  always @(posedge clk or negedge u_arst_n) begin
    if (!u_arst_n) begin
      cs_busy_i <= 1'b0;
      cs_y_bi   <= '0;
      u_cnt     <= 0;
      u_x       <= '0;
    end else if (!cs_busy_i) begin
      if (cs_start_o) begin
        cs_busy_i <= 1'b1;
        u_cnt     <= unit_b - 1;
        u_x       <= cs_x_bo;
      end
    end else if (!stub) begin
      if (u_cnt == 0) begin
        cs_busy_i <= 1'b0;
        cs_y_bi   <= icbrt(u_x);
      end else begin
        u_cnt <= u_cnt - 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_x(input int k, input logic [XW-1:0] v);
    x_bi[k*XW +: XW] = v;
  endtask

  // Serve one operation for whoever the round-robin rule picks from the
  // current req_bi, checking the whole handshake and the returned result.
  task automatic serve(input string tag, input logic [XW-1:0] exp_y,
                       input int b, input bit drop, input bit exp_err);
    int g, cyc, t_ack, acks, starts, lat;
    bit got_ack, got_done, busy_gap;
    logic [XW-1:0] exp_x;
    g = model_pick(req_bi, m_ptr);
    exp_x = x_bi[g*XW +: XW];
    unit_b = b;
    lat = exp_err ? TIMEOUT + 1 : b + 2;
    cyc = 0; t_ack = 0; acks = 0; starts = 0;
    got_ack = 0; got_done = 0; busy_gap = 0;
    while (!got_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cs_start_o) starts++;
      if (got_ack && !busy_o) busy_gap = 1;
      if (ack_bo != '0) begin
        acks++;
        if (!got_ack) begin
          chk({tag, "_ack"}, ack_bo, 32'(1) << g);
          chk({tag, "_csx"}, cs_x_bo, exp_x);
          got_ack = 1;
          t_ack = cyc;
          if (drop) begin
            req_bi[g] = 1'b0;
            set_x(g, XW'($urandom));
          end
        end
      end
      if (done_o) got_done = 1;
    end
    chk({tag, "_done_seen"}, got_done, 1);
    chk({tag, "_acks"}, acks, 1);
    chk({tag, "_starts"}, starts, 1);
    chk({tag, "_lat"}, cyc - t_ack, lat);
    chk({tag, "_busy"}, busy_gap, 0);
    chk({tag, "_id"}, id_bo, g);
    chk({tag, "_y"}, y_bo, exp_y);
    chk({tag, "_err"}, err_o, exp_err);
    chk({tag, "_xhold"}, cs_x_bo, exp_x);
    @(negedge clk);
    chk({tag, "_idle"}, {done_o, err_o, busy_o}, 3'b000);
    m_ptr = g;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [XW-1:0] yt [NREQ];
    rst_n = 1'b0; unit_rst_n = 1'b1; stub = 0; unit_b = 3;
    req_bi = '0; x_bi = '0; m_ptr = NREQ - 1;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack_bo, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_start", cs_start_o, 0);
    chk("rst_id", id_bo, 0);
    chk("rst_y", y_bo, 0);
    chk("rst_csx", cs_x_bo, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy_o, 0);

    // Single request
    set_x(0, 8'd27); req_bi = 4'b0001;
    serve("t1", 8'd3, 3, 1, 0);

    // Floor and limits
    set_x(0, 8'd16);  req_bi = 4'b0001; serve("t2a", 8'd2, 2, 1, 0);
    set_x(0, 8'd255); req_bi = 4'b0001; serve("t2b", 8'd6, 5, 1, 0);
    set_x(0, 8'd0);   req_bi = 4'b0001; serve("t2c", 8'd0, 1, 1, 0);

    // Round-robin with all requesters held
    set_x(0, 8'd1); set_x(1, 8'd8); set_x(2, 8'd64); set_x(3, 8'd125);
    yt[0] = 8'd1; yt[1] = 8'd2; yt[2] = 8'd4; yt[3] = 8'd5;
    req_bi = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve($sformatf("t3_%0d", i), yt[model_pick(req_bi, m_ptr)], 2, 0, 0);
    end

    // Contention between 0 and 2
    set_x(0, 8'd30); set_x(2, 8'd200);
    yt[0] = 8'd3; yt[2] = 8'd5;
    req_bi = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      serve($sformatf("t4_%0d", i), yt[model_pick(req_bi, m_ptr)], 3, 0, 0);
    end

    // Timeout with a unit that never drops busy, then recovery
    req_bi = 4'b0000;
    @(negedge clk);
    stub = 1;
    set_x(1, 8'd100); req_bi = 4'b0010;
    serve("t5_to", 8'd0, 3, 1, 1);
    stub = 0; unit_rst_n = 1'b0;
    @(negedge clk);
    unit_rst_n = 1'b1;
    set_x(1, 8'd200); req_bi = 4'b0010;
    serve("t5_rec", 8'd5, 4, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < NREQ; k++) set_x(k, XW'($urandom));
      req_bi = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      serve($sformatf("rnd_%0d", i), icbrt(x_bi[model_pick(req_bi, m_ptr)*XW +: XW]),
            int'($urandom_range(1, 6)), 1, 0);
    end

    // Reset in the middle of RUN
    set_x(2, 8'd99); req_bi = 4'b0100; unit_b = 20;
    n = 0;
    while (ack_bo == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_pre_ack", ack_bo, 4'b0100);
    req_bi = '0;
    repeat (5) @(negedge clk);
    chk("t6_pre_busy", busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async", {busy_o, cs_start_o, done_o, ack_bo}, 0);
    @(negedge clk);
    chk("t6_held", {busy_o, done_o, err_o, id_bo, y_bo}, 0);
    for (int k = 0; k < NREQ; k++) set_x(k, 8'd64);
    req_bi = 4'b1111;
    rst_n = 1'b1;
    m_ptr = NREQ - 1;
    serve("t6_after", 8'd4, 2, 0, 0);
    chk("t6_first_id", id_bo, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule : tb_cub_sqrt_sched
`default_nettype wire
